// File: rtl/data_memory_pkg.sv
// -----------------------------------------------------------------------------
// data_memory_pkg
// Shared constants and helpers for the MEM-stage data memory.
//   DM_ADDR_W   : default word-address width (64 words)
//   DM_DATA_W   : fixed data width
//   DM_STR_*    : halfword write-strobe encodings
//   dm_merge()  : lane merge of a stored word with write data
// -----------------------------------------------------------------------------
package data_memory_pkg;

  localparam int DM_ADDR_W = 6;
  localparam int DM_DATA_W = 32;

  localparam logic [1:0] DM_STR_NONE = 2'b00;
  localparam logic [1:0] DM_STR_LO   = 2'b01;
  localparam logic [1:0] DM_STR_HI   = 2'b10;
  localparam logic [1:0] DM_STR_WORD = 2'b11;

  // Set lanes come from new_word, clear lanes keep old_word.
  function automatic logic [DM_DATA_W-1:0] dm_merge(
    input logic [DM_DATA_W-1:0] old_word,
    input logic [DM_DATA_W-1:0] new_word,
    input logic [1:0]           str
  );
    logic [DM_DATA_W-1:0] w_word;
    w_word[15:0]  = str[0] ? new_word[15:0]  : old_word[15:0];
    w_word[31:16] = str[1] ? new_word[31:16] : old_word[31:16];
    return w_word;
  endfunction

endpackage

// File: rtl/data_memory_if.sv
// -----------------------------------------------------------------------------
// data_memory_if
// Bus bundle between the MEM stage / display selector and the data memory.
//   addr      : datapath word address (read and write)
//   disp_addr : display read address
//   din       : write data
//   str       : halfword write strobes
//   dout      : mem[addr]
//   disp_out  : mem[disp_addr]
// Modports: master (pipeline side), slave (memory side).
// -----------------------------------------------------------------------------
interface data_memory_if
  import data_memory_pkg::*;
#(
  parameter int ADDR_W = DM_ADDR_W
);

  logic [ADDR_W-1:0]    addr;
  logic [ADDR_W-1:0]    disp_addr;
  logic [DM_DATA_W-1:0] din;
  logic [1:0]           str;
  logic [DM_DATA_W-1:0] dout;
  logic [DM_DATA_W-1:0] disp_out;

  modport master (
    output addr, disp_addr, din, str,
    input  dout, disp_out
  );

  modport slave (
    input  addr, disp_addr, din, str,
    output dout, disp_out
  );

endinterface

// File: rtl/data_memory_rdport.sv
// -----------------------------------------------------------------------------
// data_memory_rdport
// One combinational read port of the data memory.
//   i_rst     : active-low reset (bypass is suppressed while low)
//   i_word    : stored word at i_rd_addr
//   i_rd_addr : this port's read address
//   i_wr_addr : datapath write address
//   i_din     : write data
//   i_str     : halfword write strobes
//   o_rdata   : read data
// With DATA_MEMORY_BYPASS_EN defined, a read hitting the address being written
// this cycle returns the merged (write-through) word; otherwise stored data only.
// -----------------------------------------------------------------------------
module data_memory_rdport
  import data_memory_pkg::*;
#(
  parameter int ADDR_W = DM_ADDR_W
) (
  input  logic                 i_rst,
  input  logic [DM_DATA_W-1:0] i_word,
  input  logic [ADDR_W-1:0]    i_rd_addr,
  input  logic [ADDR_W-1:0]    i_wr_addr,
  input  logic [DM_DATA_W-1:0] i_din,
  input  logic [1:0]           i_str,
  output logic [DM_DATA_W-1:0] o_rdata
);

`ifdef DATA_MEMORY_BYPASS_EN
  logic w_hit;

  assign w_hit = i_rst && (i_str != DM_STR_NONE) && (i_rd_addr == i_wr_addr);

  // Forward the pre-edge merged word when this port reads the write target.
  always_comb begin
    o_rdata = i_word;
    if (w_hit) begin
      o_rdata = dm_merge(i_word, i_din, i_str);
    end else begin
      o_rdata = i_word;
    end
  end
`else
  // Write-side inputs only matter for the bypass build.
  logic w_unused;
  assign w_unused = ^{1'b0, i_rst, i_rd_addr, i_wr_addr, i_din, i_str};

  // Stored contents only.
  always_comb begin
    o_rdata = i_word;
  end
`endif

endmodule

// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
// 2^ADDR_W x 32-bit word-addressed data memory for the MEM stage.
//   clk : clock, all state changes on the rising edge
//   rst : synchronous active-low reset, clears every word, beats any write
//   bus : data_memory_if.slave (addr, disp_addr, din, str, dout, disp_out)
// One lane-strobed synchronous write port; two independent combinational read
// ports (datapath at addr, display at disp_addr).
// Optional macro DATA_MEMORY_BYPASS_EN: read ports forward same-cycle write data.
// -----------------------------------------------------------------------------
module data_memory
  import data_memory_pkg::*;
#(
  parameter int ADDR_W = DM_ADDR_W
) (
  input  logic          clk,
  input  logic          rst,
  data_memory_if.slave  bus
);

  localparam int DEPTH = 32'd1 << ADDR_W;

  logic [DM_DATA_W-1:0] r_mem [DEPTH];

  // Storage: reset clears the whole array, otherwise strobed lanes take din.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {DM_DATA_W{1'b0}};
      end
    end else if (bus.str != DM_STR_NONE) begin
      r_mem[bus.addr] <= dm_merge(r_mem[bus.addr], bus.din, bus.str);
    end
  end

  data_memory_rdport #(.ADDR_W(ADDR_W)) u_rd_dp (
    .i_rst     (rst),
    .i_word    (r_mem[bus.addr]),
    .i_rd_addr (bus.addr),
    .i_wr_addr (bus.addr),
    .i_din     (bus.din),
    .i_str     (bus.str),
    .o_rdata   (bus.dout)
  );

  data_memory_rdport #(.ADDR_W(ADDR_W)) u_rd_disp (
    .i_rst     (rst),
    .i_word    (r_mem[bus.disp_addr]),
    .i_rd_addr (bus.disp_addr),
    .i_wr_addr (bus.addr),
    .i_din     (bus.din),
    .i_str     (bus.str),
    .o_rdata   (bus.disp_out)
  );

endmodule

// File: tb/tb_data_memory.sv
// -----------------------------------------------------------------------------
// tb_data_memory
// Self-checking bench for data_memory: directed scenarios plus randomized
// traffic compared against an array-based reference model.
// -----------------------------------------------------------------------------
module tb_data_memory;
  import data_memory_pkg::*;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  logic [31:0] ref_mem [64];

  data_memory_if #(.ADDR_W(6)) bus ();

  data_memory #(.ADDR_W(6)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference: what a read at address a should show before the next edge.
  function automatic logic [31:0] ref_read(input int a);
    logic [31:0] w;
    w = ref_mem[a];
`ifdef DATA_MEMORY_BYPASS_EN
    if (rst === 1'b1 && bus.str != 2'b00 && a == int'(bus.addr)) begin
      if (bus.str[0]) w = (w & 32'hFFFF_0000) | (bus.din & 32'h0000_FFFF);
      if (bus.str[1]) w = (w & 32'h0000_FFFF) | (bus.din & 32'hFFFF_0000);
    end
`endif
    return w;
  endfunction

  // One rising edge; the model applies the spec rules to the inputs present.
  task automatic step();
    if (rst === 1'b0) begin
      foreach (ref_mem[i]) ref_mem[i] = 32'h0;
    end else begin
      if (bus.str[0]) ref_mem[bus.addr][15:0]  = bus.din[15:0];
      if (bus.str[1]) ref_mem[bus.addr][31:16] = bus.din[31:16];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] s);
    bus.addr = a;
    bus.din  = d;
    bus.str  = s;
    step();
    bus.str  = 2'b00;
    #1;
  endtask

  task automatic rd_both(input logic [5:0] a, input string tag, input logic [31:0] exp);
    bus.addr      = a;
    bus.disp_addr = a;
    #1;
    check_eq({tag, "_dout"}, bus.dout, exp);
    check_eq({tag, "_disp"}, bus.disp_out, exp);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    foreach (ref_mem[i]) ref_mem[i] = $urandom;
    rst           = 1'b0;
    bus.addr      = 6'd0;
    bus.disp_addr = 6'd0;
    bus.din       = 32'h0;
    bus.str       = 2'b00;
    @(posedge clk); #1;
    step();
    rst = 1'b1;
    #1;

    // Reset clears a previously written word and the whole array.
    wr(6'd5, 32'hDEAD_BEEF, DM_STR_WORD);
    rd_both(6'd5, "pre_reset", 32'hDEAD_BEEF);
    rst = 1'b0;
    step();
    rst = 1'b1;
    #1;
    rd_both(6'd5, "reset_5", 32'h0);
    for (int i = 0; i < 64; i++) begin
      bus.addr      = i[5:0];
      bus.disp_addr = 6'(63 - i);
      #1;
      check_eq("reset_sweep_dout", bus.dout, 32'h0);
      check_eq("reset_sweep_disp", bus.disp_out, 32'h0);
    end

    // Full-word store and neighbours.
    wr(6'd3, 32'h1234_5678, DM_STR_WORD);
    rd_both(6'd3, "word3", 32'h1234_5678);
    rd_both(6'd2, "word2_untouched", 32'h0);
    rd_both(6'd4, "word4_untouched", 32'h0);

    // Halfword lanes.
    wr(6'd3, 32'hAAAA_BBBB, DM_STR_LO);
    rd_both(6'd3, "lane_lo", 32'h1234_BBBB);
    wr(6'd3, 32'hAAAA_BBBB, DM_STR_HI);
    rd_both(6'd3, "lane_hi", 32'hAAAA_BBBB);
    for (int i = 0; i < 3; i++) begin
      bus.addr = 6'd3;
      bus.din  = $urandom;
      bus.str  = DM_STR_NONE;
      step();
    end
    rd_both(6'd3, "str_none_hold", 32'hAAAA_BBBB);

    // Dual read independence.
    wr(6'd0, 32'h0000_0011, DM_STR_WORD);
    wr(6'd63, 32'hFFFF_FFFF, DM_STR_WORD);
    bus.addr      = 6'd0;
    bus.disp_addr = 6'd63;
    #1;
    check_eq("dual_dout", bus.dout, 32'h0000_0011);
    check_eq("dual_disp", bus.disp_out, 32'hFFFF_FFFF);
    bus.disp_addr = 6'd3;
    #1;
    check_eq("dual_dout_stable", bus.dout, 32'h0000_0011);
    check_eq("dual_disp_moved", bus.disp_out, 32'hAAAA_BBBB);

    // Read during write to address 7.
    bus.addr      = 6'd7;
    bus.disp_addr = 6'd7;
    bus.din       = 32'h0BAD_F00D;
    bus.str       = DM_STR_WORD;
    #1;
`ifdef DATA_MEMORY_BYPASS_EN
    check_eq("rdw_before_dout", bus.dout, 32'h0BAD_F00D);
    check_eq("rdw_before_disp", bus.disp_out, 32'h0BAD_F00D);
`else
    check_eq("rdw_before_dout", bus.dout, 32'h0);
    check_eq("rdw_before_disp", bus.disp_out, 32'h0);
`endif
    step();
    bus.str = 2'b00;
    #1;
    rd_both(6'd7, "rdw_after", 32'h0BAD_F00D);

    // Reset beats a write on the same edge.
    bus.addr = 6'd3;
    bus.din  = 32'hFFFF_FFFF;
    bus.str  = DM_STR_WORD;
    rst      = 1'b0;
    #1;
    check_eq("rst_wr_no_bypass", bus.dout, 32'hAAAA_BBBB);
    step();
    rst     = 1'b1;
    bus.str = 2'b00;
    #1;
    rd_both(6'd3, "rst_beats_wr", 32'h0);
    rd_both(6'd7, "rst_clears_7", 32'h0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      bus.addr      = 6'($urandom_range(0, 63));
      bus.disp_addr = ($urandom_range(0, 3) == 0) ? bus.addr : 6'($urandom_range(0, 63));
      bus.din       = $urandom;
      bus.str       = 2'($urandom_range(0, 3));
      rst           = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
      #1;
      check_eq("rand_dout", bus.dout, ref_read(int'(bus.addr)));
      check_eq("rand_disp", bus.disp_out, ref_read(int'(bus.disp_addr)));
      step();
    end

    // Final sweep of the whole array after random traffic.
    rst     = 1'b1;
    bus.str = 2'b00;
    for (int i = 0; i < 64; i++) begin
      bus.addr      = i[5:0];
      bus.disp_addr = 6'(63 - i);
      #1;
      check_eq("final_dout", bus.dout, ref_mem[i]);
      check_eq("final_disp", bus.disp_out, ref_mem[63 - i]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
